text_vram_mp: RTL and testbench
===============================

Name: text_vram_mp

Overview:
- Parametrised character video RAM for the HDMI text console: one CPU/UART write port, NRD synchronous read ports (port 0 feeds the display scanner; the rest feed command-match logic).
- Adds hardware scroll (circular row offset) and a hardware fill sweep (clear-screen / clear-row), so software never rewrites the whole buffer.
- All ports use logical addresses (row*COLS+col); the block maps them to physical addresses.

Parameters:
- COLS, 100, characters per row
- ROWS, 30, rows per screen
- DW, 8, character width in bits
- NRD, 6, number of read ports (>=1)
- FILL, 8'h20, character written by clear/scroll sweeps and returned for out-of-range reads
- INIT_CLEAR, 1, when 1 a full clear sweep starts automatically after reset
- Derived: DEPTH=COLS*ROWS; AW=clog2(DEPTH)

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset; synchronous, active-low
- w_addr  in  AW  logical write address
- w_data  in  DW  write data
- w_en  in  1  write strobe
- rd_addr  in  NRD*AW  packed logical read addresses; port k = bits [k*AW +: AW]
- rd_data  out  NRD*DW  packed read data; same packing
- scroll_req  in  1  one-cycle pulse: scroll up one row, blank the new bottom row
- clr_req  in  1  one-cycle pulse: blank the whole screen, reset the offset
- busy  out  1  high while a sweep is running
- top_off  out  AW  current physical address of logical (0,0); multiple of COLS

Behaviour:
- Reset (rst_n=0 at posedge): top_off=0, rd_data=0, pipeline valids cleared, state=IDLE, busy=0. Memory contents are not reset. With INIT_CLEAR=1, the state is CLR_ALL and busy=1 from the first cycle after reset release.
- Address map: phys = L + top_off; if phys >= DEPTH, subtract DEPTH. No divider.
- Read: 2-cycle latency. Stage 1 registers the translated address and an in-range flag (L < DEPTH). Stage 2 registers mem[phys], or FILL if out of range. rd_addr at cycle T gives rd_data valid after edge T+2. Reads are never stalled, including while busy.
- Write: w_en at T with busy=0 is translated and registered, and memory is written at T+1.
  - Out-of-range w_addr is dropped.
  - w_en while busy=1 is dropped.
  - w_en in the same cycle as an accepted request is dropped.
- Read/write collision: read-first. A read whose stage-2 access coincides with a write to the same physical address returns old data.
- States:
  - IDLE: clr_req (priority) -> CLR_ALL; else scroll_req -> CLR_ROW.
  - Requests are accepted only in IDLE with busy=0; requests while busy are ignored.
- Accept cycle T:
  - clr: top_off <= 0; sweep pointer <= 0; count = DEPTH.
  - scroll: sweep pointer <= old top_off; top_off <= old top_off+COLS (wraps to 0 at DEPTH); count = COLS.
  - busy=1 from T+1.
- CLR_ALL / CLR_ROW:
  - One FILL write per cycle at the sweep pointer, starting at T+1.
  - The pointer increments and wraps at DEPTH.
  - On the last write -> IDLE; busy=0 in the following cycle.
  - The memory write port is owned by the sweep whenever state != IDLE.
- Until swept, reads of the new bottom row may return stale pre-scroll characters. This is acceptable; the display refreshes.
- Scroll at top_off = DEPTH-COLS wraps top_off to 0.
- Reset mid-sweep aborts the sweep (restarting it if INIT_CLEAR=1); partial contents remain.

Decomposition:
- Package text_vram_pkg: clog2 function, DW-wide FILL constant, state enum {IDLE, CLR_ROW, CLR_ALL}.
- One natural sub-module, vram_addr_map: the combinational logical->physical translator (add, compare, subtract). It is instantiated NRD+1 times: read ports plus the write port.

Test Plan:
- Latency: INIT_CLEAR=0; write 8'h41 at L=5; read port 3 addr 5 two cycles later -> rd_data[3] = 8'h41 exactly 2 cycles after the address; rd_addr 3000 -> 8'h20.
- Scroll: fill row 1 with 8'h31, pulse scroll_req -> top_off=100; busy high exactly 100 cycles; logical row 0 now reads 8'h31; logical row 29 reads 8'h20 once busy falls.
- Wrap: issue 30 scrolls from reset -> top_off returns to 0; write then read L=2999 at top_off=2900 -> correct data via physical 2899.
- Clear: pulse clr_req with top_off=500 -> top_off=0 the next cycle; busy for 3000 cycles; every address then reads 8'h20.
- Priority/drop: clr_req and scroll_req together -> only CLR_ALL runs (3000 cycles). w_en during busy -> memory unchanged. w_en same cycle as accept -> dropped.
- Reset: assert rst_n=0 mid-CLR_ROW -> busy=0, rd_data=0, top_off=0; with INIT_CLEAR=1, busy=1 for 3000 cycles after release.

Source files
------------

// File: rtl/text_vram_pkg.sv
// -----------------------------------------------------------------------------
// text_vram_pkg
// Shared definitions for the text console video RAM:
//   clog2      - ceiling log2, used to size logical/physical addresses
//   FILL_CHAR  - default blank character (ASCII space) for an 8-bit cell
//   state_t    - sweep controller states
// -----------------------------------------------------------------------------
package text_vram_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam logic [7:0] FILL_CHAR = 8'h20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } state_t;

endpackage

// File: rtl/vram_addr_map.sv
// -----------------------------------------------------------------------------
// vram_addr_map
// Combinational logical->physical address translation for the circular
// screen buffer: phys = laddr + off, folded back once into [0, DEPTH).
// Ports:
//   i_laddr   - logical address (row*COLS+col)
//   i_off     - current physical address of logical (0,0), always < DEPTH
//   o_paddr   - physical address (only meaningful when o_inrange=1)
//   o_inrange - laddr < DEPTH
// -----------------------------------------------------------------------------
module vram_addr_map import text_vram_pkg::*; #(
  parameter int DEPTH = 3000,
  parameter int AW    = 12
) (
  input  logic [AW-1:0] i_laddr,
  input  logic [AW-1:0] i_off,
  output logic [AW-1:0] o_paddr,
  output logic          o_inrange
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW:0] w_sum;
  logic [AW:0] w_fold;

  // One extra bit keeps the sum exact; a single conditional subtract suffices
  // because both operands are below DEPTH whenever the result is used.
  always_comb begin
    w_sum     = {1'b0, i_laddr} + {1'b0, i_off};
    w_fold    = w_sum - DEPTH_C;
    o_paddr   = (w_sum >= DEPTH_C) ? w_fold[AW-1:0] : w_sum[AW-1:0];
    o_inrange = ({1'b0, i_laddr} < DEPTH_C);
  end

endmodule

// File: rtl/text_vram_mp.sv
// -----------------------------------------------------------------------------
// text_vram_mp
// Character video RAM with one write port, NRD read ports, hardware scroll
// (circular row offset) and a FILL sweep engine for clear-screen/clear-row.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   w_addr/w_data/w_en - logical write port (dropped while busy or on accept)
//   rd_addr     - NRD packed logical read addresses, port k at [k*AW +: AW]
//   rd_data     - NRD packed read data, 2-cycle latency, FILL when out of range
//   scroll_req  - pulse: advance top row, blank the new bottom row
//   clr_req     - pulse: blank the whole screen, reset offset (wins over scroll)
//   busy        - sweep in progress
//   top_off     - physical address of logical (0,0)
// -----------------------------------------------------------------------------
module text_vram_mp import text_vram_pkg::*; #(
  parameter int             COLS       = 100,
  parameter int             ROWS       = 30,
  parameter int             DW         = 8,
  parameter int             NRD        = 6,
  parameter logic [DW-1:0]  FILL       = DW'(FILL_CHAR),
  parameter int             INIT_CLEAR = 1,
  parameter int             DEPTH      = COLS * ROWS,
  parameter int             AW         = clog2(COLS * ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     w_addr,
  input  logic [DW-1:0]     w_data,
  input  logic              w_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  input  logic              scroll_req,
  input  logic              clr_req,
  output logic              busy,
  output logic [AW-1:0]     top_off
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ROW_STEP  = AW'(COLS);
  localparam logic [AW-1:0] LAST_ROW  = AW'(DEPTH - COLS);
  localparam logic [AW:0]   CNT_ALL   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ROW   = (AW+1)'(COLS);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);

  logic [DW-1:0]     r_mem [DEPTH];

  state_t            r_state;
  logic [AW-1:0]     r_top_off;
  logic [AW-1:0]     r_ptr;
  logic [AW:0]       r_cnt;

  logic [AW-1:0]     w_wphys;
  logic              w_win;
  logic              r_wv_p1;
  logic [AW-1:0]     r_wa_p1;
  logic [DW-1:0]     r_wd_p1;

  logic [AW-1:0]     w_rphys [NRD];
  logic [NRD-1:0]    w_rin;
  logic [AW-1:0]     r_rphys_p1 [NRD];
  logic [NRD-1:0]    r_rin_p1;
  logic [NRD*DW-1:0] r_rd_data_p2;

  logic              w_sweep;
  logic              w_mem_we;
  logic [AW-1:0]     w_mem_addr;
  logic [DW-1:0]     w_mem_data;

  assign busy    = (r_state != IDLE);
  assign top_off = r_top_off;
  assign rd_data = r_rd_data_p2;

  // Address translators: one per read port plus one for the write port.
  for (genvar k = 0; k < NRD; k++) begin : g_rmap
    vram_addr_map #(.DEPTH(DEPTH), .AW(AW)) u_rmap (
      .i_laddr   (rd_addr[k*AW +: AW]),
      .i_off     (r_top_off),
      .o_paddr   (w_rphys[k]),
      .o_inrange (w_rin[k])
    );
  end

  vram_addr_map #(.DEPTH(DEPTH), .AW(AW)) u_wmap (
    .i_laddr   (w_addr),
    .i_off     (r_top_off),
    .o_paddr   (w_wphys),
    .o_inrange (w_win)
  );

  // Control: sweep FSM, scroll offset and write-accept valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_top_off <= '0;
      r_wv_p1   <= 1'b0;
      r_ptr     <= '0;
      r_cnt     <= CNT_ALL;
      r_state   <= (INIT_CLEAR != 0) ? CLR_ALL : IDLE;
    end else begin
      r_wv_p1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_state   <= CLR_ALL;
            r_top_off <= '0;
            r_ptr     <= '0;
            r_cnt     <= CNT_ALL;
          end else if (scroll_req) begin
            r_state   <= CLR_ROW;
            r_ptr     <= r_top_off;
            r_top_off <= (r_top_off == LAST_ROW) ? '0 : r_top_off + ROW_STEP;
            r_cnt     <= CNT_ROW;
          end else if (w_en && w_win) begin
            r_wv_p1 <= 1'b1;
          end
        end
        default: begin
          r_ptr <= (r_ptr == LAST_ADDR) ? '0 : r_ptr + 1'b1;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= IDLE;
        end
      endcase
    end
  end

  // Write stage p1: translated address/data, qualified by r_wv_p1.
  always_ff @(posedge clk) begin
    r_wa_p1 <= w_wphys;
    r_wd_p1 <= w_data;
  end

  // The sweep owns the memory write port whenever it is running.
  always_comb begin
    w_sweep    = (r_state != IDLE);
    w_mem_we   = rst_n && (w_sweep || r_wv_p1);
    w_mem_addr = w_sweep ? r_ptr : r_wa_p1;
    w_mem_data = w_sweep ? FILL : r_wd_p1;
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  // Read stage p1: translated address.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NRD; k++) r_rphys_p1[k] <= w_rphys[k];
  end

  // Read stage p2: memory data (old data on a same-edge write), FILL if out of range.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rin_p1     <= '0;
      r_rd_data_p2 <= '0;
    end else begin
      r_rin_p1 <= w_rin;
      for (int k = 0; k < NRD; k++)
        r_rd_data_p2[k*DW +: DW] <= r_rin_p1[k] ? r_mem[r_rphys_p1[k]] : FILL;
    end
  end

endmodule

// File: tb/tb_text_vram_mp.sv
module tb_text_vram_mp;

  localparam int COLS  = 100;
  localparam int ROWS  = 30;
  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int NRD   = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_data;
  logic              w_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic              scroll_req, clr_req;
  logic              busy;
  logic [AW-1:0]     top_off;

  // second instance exercises the automatic clear after reset
  logic [AW-1:0]     i2_rd_addr;
  logic [DW-1:0]     i2_rd_data;
  logic              i2_busy;
  logic [AW-1:0]     i2_top_off;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  text_vram_mp #(.COLS(COLS), .ROWS(ROWS), .DW(DW), .NRD(NRD),
                 .FILL(8'h20), .INIT_CLEAR(0)) dut (
    .clk(clk), .rst_n(rst_n), .w_addr(w_addr), .w_data(w_data), .w_en(w_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .scroll_req(scroll_req),
    .clr_req(clr_req), .busy(busy), .top_off(top_off)
  );

  text_vram_mp #(.COLS(COLS), .ROWS(ROWS), .DW(DW), .NRD(1),
                 .FILL(8'h20), .INIT_CLEAR(1)) dut_init (
    .clk(clk), .rst_n(rst_n), .w_addr(12'd0), .w_data(8'd0), .w_en(1'b0),
    .rd_addr(i2_rd_addr), .rd_data(i2_rd_data), .scroll_req(1'b0),
    .clr_req(1'b0), .busy(i2_busy), .top_off(i2_top_off)
  );

  typedef struct {
    logic       we;
    int         addr;
    logic [7:0] data;
    int         port;
    logic [7:0] exp;
  } vec_t;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    w_addr = a[AW-1:0];
    w_data = d;
    w_en   = 1'b1;
    step(1);
    w_en   = 1'b0;
  endtask

  task automatic rd(input int port, input int a, output logic [7:0] d);
    rd_addr = '0;
    rd_addr[port*AW +: AW] = a[AW-1:0];
    step(2);
    d = rd_data[port*DW +: DW];
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 5000) begin
      step(1);
      n++;
    end
  endtask

  task automatic scroll1();
    int n;
    scroll_req = 1'b1;
    step(1);
    scroll_req = 1'b0;
    busy_len(n);
  endtask

  initial begin
    vec_t       vecs [7];
    logic [7:0] d;
    int         n;
    int         bad;

    rst_n = 1'b0; w_addr = '0; w_data = '0; w_en = 1'b0;
    rd_addr = '0; scroll_req = 1'b0; clr_req = 1'b0; i2_rd_addr = '0;

    // ---- reset state ----
    step(3);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_top_off", 64'(top_off), 64'd0);
    chk("reset_rd_data", 64'(rd_data), 64'd0);

    // ---- automatic clear after reset release (INIT_CLEAR=1 instance) ----
    rst_n = 1'b1;
    n = 0;
    while (i2_busy && n < 5000) begin
      step(1);
      n++;
    end
    chk("init_clear_len", 64'(n), 64'd3000);
    chk("init_clear_idle_main", 64'(busy), 64'd0);

    // ---- clear the main instance so contents are defined ----
    clr_req = 1'b1; step(1); clr_req = 1'b0;
    busy_len(n);
    chk("first_clear_len", 64'(n), 64'd3000);

    // ---- table-driven write/read vectors at top_off=0 ----
    vecs[0] = '{1'b1,    5, 8'h41, 3, 8'h41};
    vecs[1] = '{1'b1,    0, 8'h55, 0, 8'h55};
    vecs[2] = '{1'b1, 2999, 8'h7E, 5, 8'h7E};
    vecs[3] = '{1'b1, 3000, 8'h99, 1, 8'h20};
    vecs[4] = '{1'b1, 4095, 8'h12, 2, 8'h20};
    vecs[5] = '{1'b0,    6, 8'h00, 4, 8'h20};
    vecs[6] = '{1'b1,  250, 8'hAA, 1, 8'hAA};
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
      rd(vecs[i].port, vecs[i].addr, d);
      chk($sformatf("vec%0d_addr%0d", i, vecs[i].addr), 64'(d), 64'(vecs[i].exp));
    end

    // ---- exact 2-cycle read latency on port 3 ----
    rd(3, 0, d);
    chk("lat_pre", 64'(d), 64'h55);
    rd_addr = '0;
    rd_addr[3*AW +: AW] = 12'd5;
    step(1);
    chk("lat_1cycle_old", 64'(rd_data[3*DW +: DW]), 64'h55);
    step(1);
    chk("lat_2cycle_new", 64'(rd_data[3*DW +: DW]), 64'h41);

    // ---- read-first collision at L=5 ----
    rd(2, 5, d);
    w_addr = 12'd5; w_data = 8'h42; w_en = 1'b1;
    step(1);
    w_en = 1'b0;
    step(1);
    chk("collide_old", 64'(rd_data[2*DW +: DW]), 64'h41);
    step(1);
    chk("collide_new", 64'(rd_data[2*DW +: DW]), 64'h42);

    // ---- scroll: row 1 = 0x31, write during busy must be dropped ----
    for (int c = 0; c < COLS; c++) wr(COLS + c, 8'h31);
    scroll_req = 1'b1; step(1); scroll_req = 1'b0;
    chk("scroll_top_off", 64'(top_off), 64'd100);
    n = 0;
    while (busy && n < 5000) begin
      w_en = (n == 3);
      w_addr = 12'd50; w_data = 8'hEE;
      step(1);
      n++;
    end
    w_en = 1'b0;
    chk("scroll_busy_len", 64'(n), 64'd100);
    rd(0, 0, d);    chk("scroll_row0_first", 64'(d), 64'h31);
    rd(1, 99, d);   chk("scroll_row0_last", 64'(d), 64'h31);
    rd(4, 50, d);   chk("busy_write_dropped", 64'(d), 64'h31);
    rd(2, 2900, d); chk("scroll_row29_first", 64'(d), 64'h20);
    rd(5, 2999, d); chk("scroll_row29_last", 64'(d), 64'h20);

    // ---- wrap: advance to top_off=2900, test L=2999 -> phys 2899 ----
    for (int s = 0; s < 28; s++) scroll1();
    chk("wrap_top_off_2900", 64'(top_off), 64'd2900);
    wr(2999, 8'h5A);
    rd(3, 2999, d);
    chk("wrap_rd_2999", 64'(d), 64'h5A);
    // scroll with a same-cycle write to L=2000 (phys 1900): write must drop
    w_en = 1'b1; w_addr = 12'd2000; w_data = 8'hC3; scroll_req = 1'b1;
    step(1);
    w_en = 1'b0; scroll_req = 1'b0;
    chk("wrap_top_off_0", 64'(top_off), 64'd0);
    busy_len(n);
    rd(3, 2899, d); chk("wrap_phys_2899", 64'(d), 64'h5A);
    rd(1, 1900, d); chk("accept_write_dropped", 64'(d), 64'h20);

    // ---- clear with top_off=500 ----
    for (int s = 0; s < 5; s++) scroll1();
    chk("pre_clear_top_off", 64'(top_off), 64'd500);
    wr(7, 8'h77);
    clr_req = 1'b1; step(1); clr_req = 1'b0;
    chk("clear_top_off", 64'(top_off), 64'd0);
    busy_len(n);
    chk("clear_busy_len", 64'(n), 64'd3000);
    // pipelined scan of every address on port 0
    bad = 0;
    rd_addr = '0;
    for (int a = 0; a < DEPTH + 2; a++) begin
      rd_addr[0 +: AW] = (a < DEPTH) ? a[AW-1:0] : 12'd0;
      step(1);
      if (a >= 2 && rd_data[0 +: DW] !== 8'h20) bad++;
    end
    chk("clear_all_blank", 64'(bad), 64'd0);

    // ---- clr and scroll together: only the full clear runs ----
    scroll1();
    chk("prio_pre_top_off", 64'(top_off), 64'd100);
    clr_req = 1'b1; scroll_req = 1'b1;
    step(1);
    clr_req = 1'b0; scroll_req = 1'b0;
    chk("prio_top_off", 64'(top_off), 64'd0);
    busy_len(n);
    chk("prio_busy_len", 64'(n), 64'd3000);

    // ---- reset in the middle of a row clear ----
    rd_addr = '0;
    rd_addr[0 +: AW] = 12'd7;
    scroll_req = 1'b1; step(1); scroll_req = 1'b0;
    step(20);
    rst_n = 1'b0;
    step(1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_top_off", 64'(top_off), 64'd0);
    chk("midrst_rd_data", 64'(rd_data), 64'd0);
    step(2);
    rst_n = 1'b1;
    n = 0;
    while (i2_busy && n < 5000) begin
      step(1);
      n++;
    end
    chk("midrst_init_len", 64'(n), 64'd3000);
    chk("midrst_main_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
